// File: rtl/rom_arbiter_pkg.sv
// rtl/rom_arbiter_pkg.sv - shared constants and helpers for the ROM read arbiter
package rom_arbiter_pkg;
    localparam int cRomLatency = 1;
    localparam int cPipeDepth  = cRomLatency + 1;

    // Width of an index able to hold 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width = width + 1;
        return width;
    endfunction
endpackage

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - round-robin first-eligible picker starting at a pointer
module rr_priority_select #(
    parameter int gRequesters = 4,
    parameter int gIndexWidth = 2
) (
    input  logic [gRequesters-1:0] eligible,
    input  logic [gIndexWidth-1:0] pointer,
    output logic [gRequesters-1:0] winner,
    output logic [gIndexWidth-1:0] index,
    output logic                   any
);
    localparam logic [gIndexWidth:0] cCount = (gIndexWidth + 1)'(gRequesters);

    logic [2*gRequesters-1:0] doubled;
    logic [gRequesters-1:0]   rotated;
    logic [gIndexWidth-1:0]   offset;
    logic [gIndexWidth:0]     sum;

    always_comb begin
        // Rotating the doubled vector puts the pointer position at bit 0.
        doubled = {eligible, eligible};
        rotated = doubled[pointer +: gRequesters];
        offset  = '0;
        any     = 1'b0;
        for (int i = gRequesters - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = i[gIndexWidth-1:0];
                any    = 1'b1;
            end
        end
        sum = {1'b0, pointer} + {1'b0, offset};
        if (sum >= cCount) sum = sum - cCount;
        index  = sum[gIndexWidth-1:0];
        winner = '0;
        if (any) winner[index] = 1'b1;
    end
endmodule

// File: rtl/rom_read_arbiter.sv
// rtl/rom_read_arbiter.sv - round-robin sharing of one synchronous-read ROM among requesters
module rom_read_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int gRequesters   = 4,
    parameter int gAddressWidth = 6,
    parameter int gDataWidth    = 8
) (
    input  logic                                 iClock,
    input  logic                                 iReset,
    input  logic [gRequesters-1:0]               iRequest,
    input  logic [gRequesters*gAddressWidth-1:0] iAddress,
    output logic [gRequesters-1:0]               oGrant,
    output logic [gRequesters-1:0]               oValid,
    output logic [gDataWidth-1:0]                oData,
    output logic [gAddressWidth-1:0]             oRomAddress,
    input  logic [gDataWidth-1:0]                iRomData
);
    localparam int                 cTagWidth = clog2(gRequesters);
    localparam logic [cTagWidth:0] cCount    = (cTagWidth + 1)'(gRequesters);

    logic [cTagWidth-1:0]     pointer;
    logic [gRequesters-1:0]   eligible;
    logic [gRequesters-1:0]   winner;
    logic [cTagWidth-1:0]     win_index;
    logic                     win_any;
    logic [cTagWidth:0]       pointer_inc;
    logic [gAddressWidth-1:0] win_address;
    logic [gRequesters-1:0]   valid_decode;
    logic [cPipeDepth-1:0]    tag_valid;
    logic [cTagWidth-1:0]     tag_index [cPipeDepth];

    // Last cycle's grant doubles as the mask, so a dropped request yields one lookup.
    assign eligible = iRequest & ~oGrant;

    rr_priority_select #(
        .gRequesters (gRequesters),
        .gIndexWidth (cTagWidth)
    ) u_select (
        .eligible (eligible),
        .pointer  (pointer),
        .winner   (winner),
        .index    (win_index),
        .any      (win_any)
    );

    always_comb begin
        pointer_inc = {1'b0, win_index} + (cTagWidth + 1)'(1);
        if (pointer_inc == cCount) pointer_inc = '0;
        win_address  = iAddress[int'(win_index)*gAddressWidth +: gAddressWidth];
        valid_decode = '0;
        for (int k = 0; k < gRequesters; k++) begin
            valid_decode[k] = tag_valid[cPipeDepth-1] &&
                              (tag_index[cPipeDepth-1] == k[cTagWidth-1:0]);
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            pointer     <= '0;
            oGrant      <= '0;
            oValid      <= '0;
            oData       <= '0;
            oRomAddress <= '0;
            tag_valid   <= '0;
            for (int s = 0; s < cPipeDepth; s++) tag_index[s] <= '0;
        end else begin
            oGrant       <= winner;
            tag_valid[0] <= win_any;
            tag_index[0] <= win_index;
            for (int s = 1; s < cPipeDepth; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_index[s] <= tag_index[s-1];
            end
            if (win_any) begin
                oRomAddress <= win_address;
                pointer     <= pointer_inc[cTagWidth-1:0];
            end
            oValid <= valid_decode;
            if (tag_valid[cPipeDepth-1]) oData <= iRomData;
        end
    end
endmodule

// File: doc/rom_read_arbiter.md
# rom_read_arbiter

Round-robin read arbiter that shares one synchronous-read `GenericROM` instance between `gRequesters` independent requesters. Each requester posts an address and receives one data word with a per-requester valid strobe. The block drives the ROM address port and captures the ROM data. It sits between the FSM-side lookup clients and the ROM, so a single ROM image serves several state/output decoders.

## Interface
- `gRequesters`, 4: number of requesters N; range 1..16.
- `gAddressWidth`, 6: ROM address width AW; must match the ROM instance.
- `gDataWidth`, 8: ROM word width DW; must match the ROM instance.

- `iClock`, in, 1: single clock; all state updates on the rising edge.
- `iReset`, in, 1: asynchronous, active-high reset. Also drives the ROM's `iReset`.
- `iRequest`, in, N: per-requester request level.
- `iAddress`, in, N*AW: flattened addresses; requester k uses bits [k*AW +: AW].
- `oGrant`, out, N: one-hot, registered; high for one cycle when requester k's address is issued.
- `oValid`, out, N: one-hot, registered; high for one cycle when `oData` holds requester k's word.
- `oData`, out, DW: registered read data, shared by all requesters.
- `oRomAddress`, out, AW: registered address to the ROM `iAddress`.
- `iRomData`, in, DW: ROM `oData`; registered inside the ROM with 1-cycle latency.

## Operation
- Requester protocol: raise `iRequest[k]` with a stable `iAddress[k]`. Hold both until `oGrant[k]` is seen, then drop `iRequest[k]` or keep it high for a further lookup.
- Eligibility at edge E: `iRequest[k]` is high, and k was not granted at edge E-1. Because of this grant mask, a requester that clears its request on the grant edge gets exactly one lookup. A single requester therefore gets at most one grant every 2 cycles.
- Arbitration is round-robin with pointer P, reset value 0. The winner is the first eligible index scanning P, P+1, …, N-1, 0, …, P-1.
  - On a grant to index w, P becomes (w+1) mod N. For N that is not a power of two, w = N-1 wraps P to 0.
  - With no eligible requester, P holds and `oGrant` is 0.
- Issue at edge E: `oGrant[w]`←1, `oRomAddress`←`iAddress[w]`, tag stage 1 ← {valid, w}. With no grant, `oRomAddress` holds its previous value and the tag is invalid.
- Pipeline:
  - At E+1 the ROM registers its data and the tag moves to stage 2.
  - At E+2, `oData`←`iRomData` and `oValid[w]`←1 if the stage-2 tag is valid.
  - `oData` holds its value when no response is due.
- Throughput: one grant per cycle in total across requesters. Up to 2 lookups are in flight.
- Responses return in grant order. The arbiter has no backpressure: a requester must accept `oValid` when it arrives.
- Reset (asynchronous, any cycle):
  - `oGrant`=0, `oValid`=0, `oData`=0, `oRomAddress`=0.
  - P=0, grant mask cleared, both tag stages invalid.
  - In-flight lookups are discarded; no `oValid` is produced for them after reset is released.

## Timing
- Request high before edge E → `oGrant` high in cycle E..E+1 → `oValid`/`oData` in cycle E+2..E+3. Grant-to-data is 2 cycles.
- `oGrant`, `oValid`, `oData` and `oRomAddress` are all flop outputs; there is no combinational path from inputs to outputs.
- First edge after reset deassertion: requests are sampled normally; the grant mask is empty.

## Structure
- Package `rom_arbiter_pkg` holds:
  - `cRomLatency` = 1.
  - `cPipeDepth` = `cRomLatency` + 1.
  - A `clog2` function used for the tag/pointer width ceil(log2 N), minimum 1.
- Sub-module `rr_priority_select` (combinational):
  - Inputs: eligible vector (N), pointer P.
  - Outputs: one-hot winner, winner index, any-valid.
  - Built with a doubled-vector mask scan.
- The top level holds pointer, grant mask, tag pipeline and output registers. `GenericROM` is instantiated by the parent, not inside this block.

## Test plan
Use N=4, AW=6, DW=8, with `GenericROM` content word(a) = a XOR 8'h5A.
- Single request: k=2, address 6'd5, held until grant → `oGrant`=4'b0100 one cycle, then `oValid`=4'b0100 two cycles later with `oData`=8'h5F. No other strobes.
- All four requests held high continuously, with addresses 1, 2, 3, 4:
  - Grants run 0,1,2,3,0,… one per cycle.
  - `oValid` follows the same sequence 2 cycles later.
  - `oData` is 5B, 58, 59, 5E.
- Fairness after wrap: only requesters 1 and 3 active with P=2 → grant order 3,1,3,1.
- Same-requester masking: k=0 holds `iRequest` for 5 cycles → grants at cycles 0, 2, 4 only, each followed by `oValid[0]` 2 cycles later.
- Reset mid-flight: assert `iReset` one cycle after a grant to k=1 → all outputs 0 immediately. No `oValid` after release. The first post-reset grant goes to the lowest eligible index from P=0.
- Idle: no requests for 10 cycles → `oGrant`=0, `oValid`=0, and `oRomAddress`/`oData` stable.
